snd_play_ctrl: RTL and testbench

- Playback sequencer for the sound IP.
- Consumes the register-block settings SNDADDR, SNDSIZE, LOOP and COMMAND.
- Splits the sound buffer into word-aligned read bursts and issues them through a request/ack handshake to the memory read master.
- Throttles bursts on sample-FIFO free space and tracks play position, pause, stop, loop and end-of-buffer.

---
 rtl/snd_play_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_snd_play_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snd_play_ctrl
// Purpose  : Playback sequencer for the sound IP. Splits the sound buffer
//            into word-aligned read bursts that never cross a BURST_BYTES
//            boundary. Bursts are issued over a request/ack handshake and
//            throttled on sample-FIFO free space. The block tracks play
//            position, pause, stop, loop and end-of-buffer.
// Ports    : ACLK/ARESETN        clock, synchronous active-low reset
//            SNDADDR/SNDSIZE     buffer base / size in bytes (bits [1:0] ignored)
//            LOOP, COMMAND       loop enable; 00 stop, 01 play, 10 pause, 11 stop
//            FIFO_ROOM           free words in the sample FIFO
//            MREQ/MADDR/MLEN     burst request, byte address, length-1 in words
//            MACK, MDONE         request accepted, burst fully written
//            PLAYING, PAUSED     status
//            END_PULSE, POS      end-of-buffer pulse, next burst offset
//            LOOPCNT             loop wrap counter (SND_PLAY_LOOPCNT_EN only)
// Macro    : SND_PLAY_LOOPCNT_EN adds the 16-bit saturating LOOPCNT output
// Revision : 1.0  initial release
// ============================================================================
module snd_play_ctrl #(
  parameter int BURST_BYTES = 64,
  parameter int ROOM_W      = 10
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [28:0]       SNDADDR,
  input  logic [28:0]       SNDSIZE,
  input  logic              LOOP,
  input  logic [1:0]        COMMAND,
  input  logic [ROOM_W-1:0] FIFO_ROOM,
  output logic              MREQ,
  output logic [28:0]       MADDR,
  output logic [7:0]        MLEN,
  input  logic              MACK,
  input  logic              MDONE,
  output logic              PLAYING,
  output logic              PAUSED,
  output logic              END_PULSE,
  output logic [28:0]       POS
`ifdef SND_PLAY_LOOPCNT_EN
  ,
  output logic [15:0]       LOOPCNT
`endif
);

  localparam int C_OFF_W = $clog2(BURST_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROOM  = 3'd1,
    S_REQ   = 3'd2,
    S_DATA  = 3'd3,
    S_PAUSE = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_cmd;
  logic [28:0] r_base, w_base_nx;
  logic [28:0] r_size, w_size_nx;
  logic [28:0] r_pos, w_pos_nx;
  logic [6:0]  r_len, w_len_nx;         // current burst length in words
  logic        r_stop_seen, w_stop_seen_nx;
  logic        r_mreq, w_mreq_nx;
  logic [28:0] r_maddr, w_maddr_nx;
  logic [7:0]  r_mlen, w_mlen_nx;
  logic        r_playing, r_paused, r_end, w_end_nx;
  logic        w_wrap, w_restart;

  logic        w_start, w_stop, w_pause, w_room_ok;
  logic [28:0] w_addr, w_rem, w_bnd, w_len_full;
  logic [6:0]  w_words;

  assign w_start = (COMMAND == 2'b01) && (r_cmd != 2'b01);
  assign w_stop  = (COMMAND == 2'b00) || (COMMAND == 2'b11);
  assign w_pause = (COMMAND == 2'b10);

  // Next burst: limited by what is left of the buffer and by the distance
  // to the next BURST_BYTES boundary.
  assign w_addr     = r_base + r_pos;
  assign w_rem      = r_size - r_pos;
  assign w_bnd      = 29'(BURST_BYTES) - 29'(w_addr[C_OFF_W-1:0]);
  assign w_len_full = (w_rem < w_bnd) ? w_rem : w_bnd;
  assign w_words    = w_len_full[8:2];
  assign w_room_ok  = 32'(FIFO_ROOM) >= 32'(w_words);

  always_comb begin
    w_state_nx     = r_state;
    w_base_nx      = r_base;
    w_size_nx      = r_size;
    w_pos_nx       = r_pos;
    w_len_nx       = r_len;
    w_stop_seen_nx = r_stop_seen;
    w_mreq_nx      = r_mreq;
    w_maddr_nx     = r_maddr;
    w_mlen_nx      = r_mlen;
    w_end_nx       = 1'b0;
    w_wrap         = 1'b0;
    w_restart      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_restart = 1'b1;
          if (SNDSIZE[28:2] != 27'd0) begin
            w_base_nx  = {SNDADDR[28:2], 2'b00};
            w_size_nx  = {SNDSIZE[28:2], 2'b00};
            w_pos_nx   = '0;
            w_state_nx = S_ROOM;
          end
        end
      end
      S_ROOM: begin
        if (w_stop) begin
          w_state_nx = S_IDLE;
        end else if (w_pause) begin
          w_state_nx = S_PAUSE;
        end else if (w_room_ok) begin
          w_mreq_nx      = 1'b1;
          w_maddr_nx     = w_addr;
          w_mlen_nx      = {1'b0, w_words} - 8'd1;
          w_len_nx       = w_words;
          w_stop_seen_nx = 1'b0;
          w_state_nx     = S_REQ;
        end
      end
      S_REQ: begin
        // A stop seen at any point while waiting for MACK is remembered so
        // the burst is still accepted and then drained.
        if (w_stop) w_stop_seen_nx = 1'b1;
        if (MACK) begin
          w_mreq_nx  = 1'b0;
          w_pos_nx   = r_pos + 29'({r_len, 2'b00});
          w_state_nx = (w_stop || r_stop_seen) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (MDONE) begin
          if (w_stop) begin
            w_state_nx = S_IDLE;
          end else if (r_pos == r_size) begin
            w_end_nx = 1'b1;
            if (LOOP) begin
              w_wrap     = 1'b1;
              w_pos_nx   = '0;
              w_state_nx = S_ROOM;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else if (w_pause) begin
            w_state_nx = S_PAUSE;
          end else begin
            w_state_nx = S_ROOM;
          end
        end
      end
      S_PAUSE: begin
        if (COMMAND == 2'b01) w_state_nx = S_ROOM;
        else if (w_stop)      w_state_nx = S_IDLE;
      end
      S_DRAIN: begin
        if (MDONE) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // COMMAND is sampled even during reset so that a play level held across
  // a reset does not look like a fresh start edge afterwards.
  always_ff @(posedge ACLK) begin
    r_cmd <= COMMAND;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_size      <= '0;
      r_pos       <= '0;
      r_len       <= '0;
      r_stop_seen <= 1'b0;
      r_mreq      <= 1'b0;
      r_maddr     <= '0;
      r_mlen      <= '0;
      r_playing   <= 1'b0;
      r_paused    <= 1'b0;
      r_end       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_base      <= w_base_nx;
      r_size      <= w_size_nx;
      r_pos       <= w_pos_nx;
      r_len       <= w_len_nx;
      r_stop_seen <= w_stop_seen_nx;
      r_mreq      <= w_mreq_nx;
      r_maddr     <= w_maddr_nx;
      r_mlen      <= w_mlen_nx;
      r_playing   <= (w_state_nx != S_IDLE);
      r_paused    <= (w_state_nx == S_PAUSE);
      r_end       <= w_end_nx;
    end
  end

  assign MREQ      = r_mreq;
  assign MADDR     = r_maddr;
  assign MLEN      = r_mlen;
  assign PLAYING   = r_playing;
  assign PAUSED    = r_paused;
  assign END_PULSE = r_end;
  assign POS       = r_pos;

`ifdef SND_PLAY_LOOPCNT_EN
  logic [15:0] r_loopcnt;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_loopcnt <= '0;
    end else if (w_restart) begin
      r_loopcnt <= '0;
    end else if (w_wrap && (r_loopcnt != 16'hFFFF)) begin
      r_loopcnt <= r_loopcnt + 16'd1;
    end
  end

  assign LOOPCNT = r_loopcnt;

  logic w_unused;
  assign w_unused = &{1'b0, SNDADDR[1:0], SNDSIZE[1:0], w_len_full[28:9],
                      w_len_full[1:0]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, SNDADDR[1:0], SNDSIZE[1:0], w_len_full[28:9],
                      w_len_full[1:0], w_wrap, w_restart};
`endif

endmodule
`default_nettype wire

// File: tb/tb_snd_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snd_play_ctrl
// Purpose  : Self-checking bench for snd_play_ctrl. Expected burst lists are
//            derived from the buffer layout with plain arithmetic. The bench
//            plays the memory master (MACK/MDONE) with random latencies.
// Macro    : SND_PLAY_LOOPCNT_EN enables LOOPCNT connection and checks
// Revision : 1.0  initial release
// ============================================================================
module tb_snd_play_ctrl;

  localparam int BB = 64;
  localparam int RW = 10;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [28:0]   SNDADDR, SNDSIZE;
  logic          LOOP;
  logic [1:0]    COMMAND;
  logic [RW-1:0] FIFO_ROOM;
  logic          MREQ;
  logic [28:0]   MADDR;
  logic [7:0]    MLEN;
  logic          MACK, MDONE;
  logic          PLAYING, PAUSED, END_PULSE;
  logic [28:0]   POS;
`ifdef SND_PLAY_LOOPCNT_EN
  logic [15:0]   LOOPCNT;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [28:0] q_addr[$];
  logic [7:0]  q_len[$];
  logic [28:0] q_pos[$];

  snd_play_ctrl #(.BURST_BYTES(BB), .ROOM_W(RW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .SNDADDR(SNDADDR), .SNDSIZE(SNDSIZE),
    .LOOP(LOOP), .COMMAND(COMMAND), .FIFO_ROOM(FIFO_ROOM), .MREQ(MREQ),
    .MADDR(MADDR), .MLEN(MLEN), .MACK(MACK), .MDONE(MDONE),
    .PLAYING(PLAYING), .PAUSED(PAUSED), .END_PULSE(END_PULSE), .POS(POS)
`ifdef SND_PLAY_LOOPCNT_EN
    , .LOOPCNT(LOOPCNT)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference burst list: walk the buffer, cutting at every BB boundary.
  task automatic build_bursts(input logic [28:0] base, input logic [28:0] size);
    int unsigned a, rem, l, pos;
    q_addr.delete(); q_len.delete(); q_pos.delete();
    a   = {3'b0, base} & 32'hFFFF_FFFC;
    rem = {3'b0, size} & 32'hFFFF_FFFC;
    pos = 0;
    while (rem > 0) begin
      l = BB - (a % BB);
      if (rem < l) l = rem;
      pos += l;
      q_addr.push_back(29'(a));
      q_len.push_back(8'(l / 4 - 1));
      q_pos.push_back(29'(pos));
      a   += l;
      rem -= l;
    end
  endtask

  task automatic wait_mreq();
    int n = 0;
    while (MREQ !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("mreq_wait", {31'b0, MREQ}, 32'd1);
  endtask

  task automatic do_burst(input logic [28:0] ea, input logic [7:0] el,
                          input logic [28:0] epos, input int ad, input int dd,
                          input logic [1:0] cmd_done);
    wait_mreq();
    chk("maddr", {3'b0, MADDR}, {3'b0, ea});
    chk("mlen", {24'b0, MLEN}, {24'b0, el});
    repeat (ad) tick();
    chk("mreq_held", {31'b0, MREQ}, 32'd1);
    chk("maddr_held", {3'b0, MADDR}, {3'b0, ea});
    MACK = 1'b1;
    tick();
    MACK = 1'b0;
    chk("mreq_drop", {31'b0, MREQ}, 32'd0);
    chk("pos_ack", {3'b0, POS}, {3'b0, epos});
    repeat (dd) tick();
    MDONE   = 1'b1;
    COMMAND = cmd_done;
    tick();
    MDONE   = 1'b0;
  endtask

  task automatic start_play(input logic [28:0] base, input logic [28:0] size, input logic lp);
    COMMAND = 2'b00;
    tick();
    tick();
    SNDADDR = base;
    SNDSIZE = size;
    LOOP    = lp;
    COMMAND = 2'b01;
  endtask

  task automatic play_run(input logic [28:0] base, input logic [28:0] size, input int dmax);
    int nb;
    build_bursts(base, size);
    start_play(base, size, 1'b0);
    nb = q_addr.size();
    for (int i = 0; i < nb; i++) begin
      do_burst(q_addr[i], q_len[i], q_pos[i], int'($urandom_range(dmax, 0)),
               int'($urandom_range(dmax, 0)), 2'b01);
      chk("end_pulse", {31'b0, END_PULSE}, (i == nb - 1) ? 32'd1 : 32'd0);
    end
    chk("idle_playing", {31'b0, PLAYING}, 32'd0);
    tick();
    chk("end_one_cycle", {31'b0, END_PULSE}, 32'd0);
  endtask

  initial begin
    int seen;
    ARESETN   = 1'b0;
    SNDADDR   = '0;
    SNDSIZE   = '0;
    LOOP      = 1'b0;
    COMMAND   = 2'b00;
    FIFO_ROOM = RW'(512);
    MACK      = 1'b0;
    MDONE     = 1'b0;
    tick();
    tick();
    chk("rst_mreq", {31'b0, MREQ}, 32'd0);
    chk("rst_maddr", {3'b0, MADDR}, 32'd0);
    chk("rst_mlen", {24'b0, MLEN}, 32'd0);
    chk("rst_playing", {31'b0, PLAYING}, 32'd0);
    chk("rst_paused", {31'b0, PAUSED}, 32'd0);
    chk("rst_end", {31'b0, END_PULSE}, 32'd0);
    chk("rst_pos", {3'b0, POS}, 32'd0);
    ARESETN = 1'b1;
    tick();

    // Aligned 256-byte buffer, no loop
    play_run(29'h1000, 29'h100, 2);
    chk("t1_pos", {3'b0, POS}, 32'h100);

    // Unaligned base and size
    play_run(29'h1033, 29'h52, 1);
    chk("t2_pos", {3'b0, POS}, 32'h50);

    // Size below one word: start ignored
    start_play(29'h6000, 29'h3, 1'b0);
    repeat (5) tick();
    chk("small_playing", {31'b0, PLAYING}, 32'd0);
    chk("small_mreq", {31'b0, MREQ}, 32'd0);

    // Looping one-burst buffer; stop on the 4th MDONE beats end-of-buffer
    start_play(29'h5000, 29'h40, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      do_burst(29'h5000, 8'd15, 29'h40, int'($urandom_range(2, 0)),
               int'($urandom_range(2, 0)), 2'b01);
      chk("loop_end", {31'b0, END_PULSE}, 32'd1);
      chk("loop_pos0", {3'b0, POS}, 32'd0);
`ifdef SND_PLAY_LOOPCNT_EN
      chk("loopcnt", {16'b0, LOOPCNT}, 32'(i));
`endif
    end
    do_burst(29'h5000, 8'd15, 29'h40, 0, 1, 2'b00);
    chk("stop_beats_end", {31'b0, END_PULSE}, 32'd0);
    chk("stop_idle", {31'b0, PLAYING}, 32'd0);
`ifdef SND_PLAY_LOOPCNT_EN
    chk("loopcnt_hold", {16'b0, LOOPCNT}, 32'd3);
`endif

    // Pause after burst 2 of 4, resume without restart
    start_play(29'h2000, 29'h100, 1'b0);
    do_burst(29'h2000, 8'd15, 29'h40, 1, 1, 2'b01);
    do_burst(29'h2040, 8'd15, 29'h80, 0, 2, 2'b10);
    chk("paused", {31'b0, PAUSED}, 32'd1);
    chk("paused_playing", {31'b0, PLAYING}, 32'd1);
    seen = 0;
    repeat (20) begin
      tick();
      if (MREQ !== 1'b0) seen++;
    end
    chk("pause_no_mreq", 32'(seen), 32'd0);
    chk("pause_pos", {3'b0, POS}, 32'h80);
    COMMAND = 2'b01;
    do_burst(29'h2080, 8'd15, 29'hC0, 1, 0, 2'b01);
    chk("resume_paused", {31'b0, PAUSED}, 32'd0);
    do_burst(29'h20C0, 8'd15, 29'h100, 0, 0, 2'b01);
    chk("resume_end", {31'b0, END_PULSE}, 32'd1);

    // FIFO throttle, then stop in REQ -> drain without END_PULSE
    FIFO_ROOM = RW'(15);
    start_play(29'h3000, 29'h40, 1'b0);
    seen = 0;
    repeat (12) begin
      tick();
      if (MREQ !== 1'b0) seen++;
    end
    chk("room_block", 32'(seen), 32'd0);
    FIFO_ROOM = RW'(16);
    tick();
    chk("room_mreq", {31'b0, MREQ}, 32'd1);
    chk("room_maddr", {3'b0, MADDR}, 32'h3000);
    COMMAND = 2'b00;
    tick();
    chk("req_hold_stop", {31'b0, MREQ}, 32'd1);
    MACK = 1'b1;
    tick();
    MACK = 1'b0;
    chk("drain_mreq", {31'b0, MREQ}, 32'd0);
    chk("drain_playing", {31'b0, PLAYING}, 32'd1);
    chk("drain_pos", {3'b0, POS}, 32'h40);
    tick();
    tick();
    chk("drain_wait", {31'b0, PLAYING}, 32'd1);
    MDONE = 1'b1;
    tick();
    MDONE = 1'b0;
    chk("drain_idle", {31'b0, PLAYING}, 32'd0);
    chk("drain_no_end", {31'b0, END_PULSE}, 32'd0);
    FIFO_ROOM = RW'(512);

    // Reset during DATA
    start_play(29'h4000, 29'h100, 1'b0);
    wait_mreq();
    MACK = 1'b1;
    tick();
    MACK = 1'b0;
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    chk("mrst_mreq", {31'b0, MREQ}, 32'd0);
    chk("mrst_maddr", {3'b0, MADDR}, 32'd0);
    chk("mrst_mlen", {24'b0, MLEN}, 32'd0);
    chk("mrst_playing", {31'b0, PLAYING}, 32'd0);
    chk("mrst_paused", {31'b0, PAUSED}, 32'd0);
    chk("mrst_pos", {3'b0, POS}, 32'd0);
    repeat (10) tick();
    chk("mrst_need_edge", {31'b0, PLAYING}, 32'd0);
    play_run(29'h4000, 29'h100, 1);

    // Randomized buffers
    for (int k = 0; k < 8; k++) begin
      FIFO_ROOM = RW'($urandom_range(1023, 64));
      play_run(29'($urandom & 32'h0FFF_FFFF), 29'($urandom_range(512, 4)), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
